// File: rtl/cpu_flashram_queue.sv
// rtl/cpu_flashram_queue.sv - CPU bus register slave with a queue of pending flashram operations
module cpu_flashram_queue #(
  parameter int CHANNELS    = 1,
  parameter int QUEUE_DEPTH = 4,
  parameter int BUF_WORDS   = 32,
  parameter int SECTOR_W    = 10,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int BUF_AW     = $clog2(BUF_WORDS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                bus_request,
  input  logic [BUF_AW+2:0]   bus_address,
  input  logic [3:0]          bus_wmask,
  input  logic [31:0]         bus_wdata,
  output logic                bus_ack,
  output logic [31:0]         bus_rdata,
  input  logic                op_request,
  input  logic [CH_W-1:0]     op_channel,
  input  logic                op_write_or_erase,
  input  logic                op_sector_or_all,
  input  logic [SECTOR_W-1:0] op_sector,
  output logic                op_done,
  output logic [CH_W-1:0]     op_done_channel,
  output logic [BUF_AW-1:0]   buf_address,
  input  logic [31:0]         buf_rdata,
  output logic                irq
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = SECTOR_W + CH_W + 2;
  localparam int OFF_W = BUF_AW + 2;

  // entry layout: {sector, channel, sector_or_all, write_or_erase}
  logic [ENT_W-1:0] fifo_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             irq_en;

  logic             buf_sel_q;
  logic [31:0]      reg_rdata_q;

  logic             is_buf;
  logic             is_write;
  logic [OFF_W-1:0] reg_off;
  logic             sel_head;
  logic             sel_status;
  logic             done_cmd;
  logic             full;
  logic             pop;
  logic             push;
  logic             reject;
  logic             clr_ovf;
  logic             ld_ien;
  logic [ENT_W-1:0] head;
  logic [31:0]      head_word;
  logic [31:0]      status_word;
  logic [31:0]      reg_rdata_next;
  logic             unused_bits;

  assign unused_bits = ^{bus_wdata[31:17], bus_wdata[15:10], bus_wdata[8:1], bus_wmask[3]};

  assign is_buf      = bus_address[BUF_AW+2];
  assign is_write    = |bus_wmask;
  assign reg_off     = bus_address[BUF_AW+1:0];
  assign buf_address = bus_address[BUF_AW+1:2];

  assign sel_head   = bus_request && !is_buf && (reg_off == OFF_W'(0));
  assign sel_status = bus_request && !is_buf && (reg_off == OFF_W'(4));

  assign done_cmd = sel_head && bus_wmask[0] && bus_wdata[0];
  assign clr_ovf  = sel_status && bus_wmask[1] && bus_wdata[9];
  assign ld_ien   = sel_status && bus_wmask[2];

  // A pop in the same cycle frees a slot, so a push into a full queue is still accepted.
  assign full   = (count == CNT_W'(QUEUE_DEPTH));
  assign pop    = done_cmd && (count != '0);
  assign push   = op_request && (!full || pop);
  assign reject = op_request && full && !pop;

  assign head = fifo_mem[rd_ptr];

  // Head register view; every field reads zero while the queue is empty.
  always_comb begin
    head_word = '0;
    if (count != '0) begin
      head_word[0]               = 1'b1;
      head_word[1]               = head[0];
      head_word[2]               = head[1];
      head_word[CH_W+3:4]        = head[CH_W+1:2];
      head_word[SECTOR_W+15:16]  = head[ENT_W-1:CH_W+2];
    end
  end

  // Status register view.
  always_comb begin
    status_word       = '0;
    status_word[6:0]  = 7'(count);
    status_word[8]    = full;
    status_word[9]    = overflow;
    status_word[16]   = irq_en;
  end

  // Register read mux; writes and unmapped offsets return zero.
  always_comb begin
    reg_rdata_next = '0;
    if (!is_write) begin
      if (sel_head)
        reg_rdata_next = head_word;
      else if (sel_status)
        reg_rdata_next = status_word;
    end
  end

  // Bus handshake: one ack per request, register data captured with the request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus_ack     <= 1'b0;
      buf_sel_q   <= 1'b0;
      reg_rdata_q <= '0;
    end else begin
      bus_ack     <= bus_request;
      buf_sel_q   <= bus_request && is_buf && !is_write;
      reg_rdata_q <= reg_rdata_next;
    end
  end

  // Buffer reads return the page buffer's registered output in the ack cycle.
  assign bus_rdata = !bus_ack ? 32'd0 : (buf_sel_q ? buf_rdata : reg_rdata_q);

  // Descriptor storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {op_sector, op_channel, op_sector_or_all, op_write_or_erase};
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow and interrupt enable; a rejected push beats a clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (reject)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
      if (ld_ien)
        irq_en <= bus_wdata[16];
    end
  end

  // Completion pulse toward the core whose operation was retired.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_done         <= 1'b0;
      op_done_channel <= '0;
    end else begin
      op_done <= pop;
      if (pop)
        op_done_channel <= head[CH_W+1:2];
    end
  end

  // Level interrupt while enabled and work is pending.
  always_ff @(posedge clk) begin
    if (!reset_n)
      irq <= 1'b0;
    else
      irq <= irq_en && (count != '0);
  end

endmodule

// File: doc/cpu_flashram_queue.md
Name: cpu_flashram_queue

Overview:
- CPU-bus register slave for FlashRAM save emulation; successor to the single-operation FlashRAM CPU register block.
- Adds multi-channel support and a FIFO of pending erase/write operations, so back-to-back N64 commands are not lost while firmware services earlier ones.
- Adds overflow detection, an interrupt, and a parametrised page-buffer window.
- Sits between the CPU bus fabric and one or more flashram emulation cores.

Parameters:
- CHANNELS, 1, number of flashram cores feeding the queue (1..16); CH_W = max(1, $clog2(CHANNELS)).
- QUEUE_DEPTH, 4, FIFO entries (power of two, 2..64).
- BUF_WORDS, 32, 32-bit words in the page-buffer window (power of two); BUF_AW = $clog2(BUF_WORDS).
- SECTOR_W, 10, sector index width (≤16).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- bus_request  in  1  CPU bus access strobe, one cycle
- bus_address  in  BUF_AW+3  byte address; MSB=1 selects buffer window, MSB=0 selects registers
- bus_wmask  in  4  byte write enables; all-zero means read
- bus_wdata  in  32  write data
- bus_ack  out  1  access acknowledge
- bus_rdata  out  32  read data, valid only while bus_ack=1, else 0
- op_request  in  1  pulse: a flashram core posts an operation
- op_channel  in  CH_W  posting core index
- op_write_or_erase  in  1  1=write, 0=erase
- op_sector_or_all  in  1  1=single sector, 0=chip erase
- op_sector  in  SECTOR_W  target sector
- op_done  out  1  one-cycle completion pulse
- op_done_channel  out  CH_W  core that op_done addresses
- buf_address  out  BUF_AW  word index into page buffer, = bus_address[BUF_AW+1:2], combinational
- buf_rdata  in  32  page-buffer data, valid one cycle after buf_address
- irq  out  1  level interrupt

Behaviour:
- Reset (reset_n=0 at clk edge): bus_ack=0, bus_rdata=0, FIFO empty, overflow=0, irq_en=0, op_done=0, op_done_channel=0, irq=0. Reset mid-operation discards all queued entries; no op_done is emitted.
- Bus: request at edge T gives bus_ack=1 for exactly one cycle at T+1.
  - Register read data is sampled at T and registered.
  - Buffer read data is buf_rdata at T+1.
  - Back-to-back requests each get their own ack.
- Register map (byte offsets; unlisted offsets read 0, writes ignored):
  - 0x00 HEAD
    - Read: [0] valid (FIFO non-empty), [1] write_or_erase, [2] sector_or_all, [CH_W+3:4] channel, [SECTOR_W+15:16] sector, all from FIFO head. All fields read 0 when empty.
    - Write: wmask[0] and wdata[0]=1 means DONE.
  - 0x04 STATUS
    - Read: [6:0] count, [8] full, [9] overflow, [16] irq_en.
    - Write: wmask[1] and wdata[9]=1 clears overflow. wmask[2] loads irq_en from wdata[16].
- Push: op_request at edge T with FIFO not full stores the descriptor; count increments at T+1.
- Push when full: descriptor dropped, overflow set at T+1 (sticky).
- DONE at edge T, FIFO non-empty:
  - Head popped at T+1.
  - op_done=1 at T+1 for one cycle, with op_done_channel = popped entry's channel.
- DONE at edge T, FIFO empty: no pop, no op_done.
- Simultaneous push and DONE on the same edge:
  - Both take effect and count is unchanged.
  - When the FIFO is full, the pop frees the slot, so the push is accepted and overflow stays 0.
  - When empty, DONE is ignored and the push is accepted.
- Overflow clear coinciding with a rejected push: the set wins, so overflow stays 1.
- FIFO pointers wrap modulo QUEUE_DEPTH; count ranges 0..QUEUE_DEPTH; full means count==QUEUE_DEPTH.
- irq = irq_en & (count≠0), registered, so it follows state with one-cycle latency.
- Buffer window writes are ignored but still acked. Buffer writes belong to the flashram cores.

Test Plan:
- Reset then read 0x04 → ack one cycle after request, rdata=0x00000000; irq=0; op_done=0.
- Post write ch=1 sector=0x155, then read 0x00 → rdata = 0x0155_0017 (valid=1, w=1, sector_or_all=1, channel=1 in bits [4]); count=1.
- QUEUE_DEPTH=4: post 5 ops → count=4, full=1, overflow=1; fifth descriptor absent after four DONEs; write 0x04 with wdata[9]=1, wmask=0b0010 → overflow=0.
- DONE with the FIFO full and a push on the same edge → count stays 4, overflow=0, op_done pulses once with the old head's channel.
- Enable irq (0x04, wdata=0x00010000, wmask=0b0100), post one op → irq=1; DONE → irq=0 two cycles after the request edge; DONE on empty → no op_done pulse.
- Read 0x80+4·k for k=0..31 → buf_address=k; rdata equals the buffer model word k at ack; assert reset_n=0 with 3 entries queued → count=0, no op_done.
